// File: rtl/counter_scoreboard.sv
// Compares behavioural and synthesized counter outputs every clk; reports counts, flags and the first mismatch.
// Optional: define SB_RCO_STATS_EN to add the rco_cnt / syn_rco_cnt statistics outputs.
module counter_scoreboard #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 8,
  parameter int SETTLE_CYC  = 2,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] syn_Q,
  input  logic             RCO,
  input  logic             syn_RCO,
  input  logic             LOAD,
  input  logic             syn_LOAD,
  output logic [1:0]       state,
  output logic             err,
  output logic             err_flag,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cmp_cycles,
  output logic [WIDTH-1:0] first_q,
  output logic [WIDTH-1:0] first_syn_q,
  output logic [2:0]       first_vec,
  output logic [CNT_W-1:0] first_cyc
`ifdef SB_RCO_STATS_EN
  ,
  output logic [CNT_W-1:0] rco_cnt,
  output logic [CNT_W-1:0] syn_rco_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_SETTLE  = 2'b01,
    S_COMPARE = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t          cur_state;
  state_t          next_state;
  logic [SW-1:0]   settle_cnt;
  logic            settle_last;
  logic [2:0]      diff;
  logic            mismatch;
  logic            first_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign state = cur_state;

  // Case-equality so that X/Z on either side is treated as a divergence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    diff        = {Q !== syn_Q, RCO !== syn_RCO, LOAD !== syn_LOAD};
    mismatch    = |diff;
    first_hit   = mismatch && !err_flag;
    settle_last = (int'(settle_cnt) == SETTLE_CYC - 1);
    next_state  = cur_state;
    unique case (cur_state)
      S_IDLE:    if (ENABLE) next_state = (SETTLE_CYC == 0) ? S_COMPARE : S_SETTLE;
      S_SETTLE:  if (!ENABLE) next_state = S_IDLE;
                 else if (settle_last) next_state = S_COMPARE;
      S_COMPARE: if (HALT_ON_ERR && first_hit) next_state = S_HALT;
                 else if (!ENABLE) next_state = S_IDLE;
      S_HALT:    next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET || CLR) cur_state <= S_IDLE;
    else              cur_state <= next_state;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (RESET || CLR) begin
      settle_cnt   <= '0;
      err          <= 1'b0;
      err_flag     <= 1'b0;
      mismatch_cnt <= '0;
      cmp_cycles   <= '0;
      first_q      <= '0;
      first_syn_q  <= '0;
      first_vec    <= '0;
      first_cyc    <= '0;
`ifdef SB_RCO_STATS_EN
      rco_cnt      <= '0;
      syn_rco_cnt  <= '0;
`endif
    end else begin
      err        <= 1'b0;
      settle_cnt <= (cur_state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (cur_state == S_COMPARE) begin
        cmp_cycles <= sat_inc(cmp_cycles);
        if (mismatch) begin
          err          <= 1'b1;
          mismatch_cnt <= sat_inc(mismatch_cnt);
        end
        // first_cyc takes the pre-increment cycle count.
        if (first_hit) begin
          err_flag    <= 1'b1;
          first_q     <= Q;
          first_syn_q <= syn_Q;
          first_vec   <= diff;
          first_cyc   <= cmp_cycles;
        end
`ifdef SB_RCO_STATS_EN
        if (RCO)     rco_cnt     <= sat_inc(rco_cnt);
        if (syn_RCO) syn_rco_cnt <= sat_inc(syn_rco_cnt);
`endif
      end
    end
  end

endmodule
